// File: rtl/riscv_pkg.sv
// Shared definitions for the boot loader slice:
// loader/receiver state encodings and length-field width.
package riscv_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/instr_loader_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling,
// one-cycle byte_valid / ferr pulses.
module uart_rx
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;
  logic          rx_s;

  assign rx_s       = sync_q[1];
  assign byte_valid = bv_q;
  assign byte_data  = sh_q;
  assign ferr       = fe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was a glitch
          state_d = rx_s ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          bv_d    = rx_s;
          fe_d    = !rx_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Serial boot loader: length-prefixed image over UART,
// written word by word into instruction memory.
module instr_loader
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 64
) (
  input  logic        clk,
  input  logic        async_reset,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int WW = $clog2(MAX_WORDS) + 1;
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

  logic             bv;
  logic [7:0]       rx_byte;
  logic             fe;

  ld_state_e        state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [WW-1:0]    widx_q, widx_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [31:0]      asm_q, asm_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wd_q, wd_d;

  logic [LEN_W-1:0] cnt_new;
  logic [WW-1:0]    widx_inc;
  logic [31:0]      word_nxt;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (async_reset),
    .rx        (rx),
    .byte_valid(bv),
    .byte_data (rx_byte),
    .ferr      (fe)
  );

  assign cnt_new  = {rx_byte, count_q[7:0]};
  assign widx_inc = widx_q + 1'b1;
  assign word_nxt = {rx_byte, asm_q[31:8]};

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign cpu_hold = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERR);

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q <= LEN_LO;
      count_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    unique case (state_q)
      LEN_LO: begin
        if (fe) begin
          state_d = ERR;
        end else if (bv) begin
          count_d[7:0] = rx_byte;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fe) begin
          state_d = ERR;
        end else if (bv) begin
          count_d = cnt_new;
          widx_d  = '0;
          bidx_d  = '0;
          if (cnt_new == '0)      state_d = DONE;
          else if (cnt_new > MAX_N) state_d = ERR;
          else                    state_d = DATA;
        end
      end
      DATA: begin
        if (fe) begin
          state_d = ERR;
        end else if (bv) begin
          asm_d  = word_nxt;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) begin
            we_d   = 1'b1;
            wd_d   = word_nxt;
            addr_d = {{(30-WW){1'b0}}, widx_q, 2'b00};
            widx_d = widx_inc;
            if ({{(LEN_W-WW){1'b0}}, widx_inc} == count_q)
              state_d = DONE;
          end
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed UART images,
// expected memory writes queued and checked by a monitor.
module tb_instr_loader;

  localparam int CPB = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        last;
  } wr_t;

  logic        clk = 1'b0;
  logic        async_reset = 1'b0;
  logic        rx = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  instr_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (64)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .rx         (rx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (async_reset && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h wd %h want none",
                 mem_addr, mem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wd, e.wd);
        chk("wr_done", {31'b0, done}, {31'b0, e.last});
        chk("wr_hold", {31'b0, cpu_hold}, {31'b0, !e.last});
      end
    end
  end

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop;
    bit_time();
    rx = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, error}, 32'd0);
  endtask

  task automatic do_reset();
    #2 async_reset = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #2 async_reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic settle_and_check(input string nm, input logic d,
                                  input logic er);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({nm, "_pending"}, exp_q.size(), 32'd0);
    chk({nm, "_done"}, {31'b0, done}, {31'b0, d});
    chk({nm, "_err"}, {31'b0, error}, {31'b0, er});
    chk({nm, "_hold"}, {31'b0, cpu_hold}, {31'b0, !d});
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] w,
                      input logic l);
    wr_t e;
    e.addr = a;
    e.wd   = w;
    e.last = l;
    exp_q.push_back(e);
  endtask

  initial begin
    // N=2 load
    do_reset();
    push(32'h0, 32'h0050_0093, 1'b0);
    push(32'h4, 32'h00A0_0113, 1'b1);
    send_ok(8'h02); send_ok(8'h00);
    send_ok(8'h93); send_ok(8'h00); send_ok(8'h50); send_ok(8'h00);
    send_ok(8'h13); send_ok(8'h01); send_ok(8'hA0); send_ok(8'h00);
    settle_and_check("n2", 1'b1, 1'b0);
    send_ok(8'h55);
    settle_and_check("n2_after", 1'b1, 1'b0);

    // zero-length image
    do_reset();
    send_ok(8'h00); send_ok(8'h00);
    settle_and_check("n0", 1'b1, 1'b0);

    // oversize image, trailing traffic ignored
    do_reset();
    send_ok(8'h41); send_ok(8'h00);
    settle_and_check("n65", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_ok(8'(8'h10 + i));
    settle_and_check("n65_after", 1'b0, 1'b1);

    // framing error on 3rd data byte of word 0
    do_reset();
    send_ok(8'h01); send_ok(8'h00);
    send_ok(8'hAA); send_ok(8'hBB);
    send_byte(8'hCC, 1'b0);
    settle_and_check("ferr", 1'b0, 1'b1);

    // 1-cycle glitch then N=1 image
    do_reset();
    @(posedge clk);
    rx = 1'b0;
    @(posedge clk);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    push(32'h0, 32'hDEAD_BEEF, 1'b1);
    send_ok(8'h01); send_ok(8'h00);
    send_ok(8'hEF); send_ok(8'hBE); send_ok(8'hAD); send_ok(8'hDE);
    settle_and_check("glitch", 1'b1, 1'b0);

    // reset mid-frame during word 1, then fresh N=1 image
    do_reset();
    push(32'h0, 32'h1111_2222, 1'b0);
    send_ok(8'h02); send_ok(8'h00);
    send_ok(8'h22); send_ok(8'h22); send_ok(8'h11); send_ok(8'h11);
    send_ok(8'h33); send_ok(8'h44);
    rx = 1'b0;
    repeat (6) @(posedge clk);
    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_word0: got %0d pending want 0", exp_q.size());
    end
    do_reset();
    push(32'h0, 32'h1234_5678, 1'b1);
    send_ok(8'h01); send_ok(8'h00);
    send_ok(8'h78); send_ok(8'h56); send_ok(8'h34); send_ok(8'h12);
    settle_and_check("midrst", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Serial boot loader sitting directly upstream of the instruction memory. Receives a program image over a UART line (8N1) and assembles it into little-endian 32-bit words. Writes the words to consecutive word addresses through a memory write port, then releases the core. Holds the processor in reset until the image is fully written.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- MAX_WORDS, 64, instruction memory depth in words; larger images are rejected.

Ports:
- clk  input  1  system clock; one clock domain, all logic rising-edge.
- async_reset  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- mem_we  output  1  instruction memory write strobe, one-cycle pulse per word.
- mem_addr  output  32  byte address of the word being written (word index × 4).
- mem_wd  output  32  word being written.
- cpu_hold  output  1  high keeps the core in reset; low releases it.
- done  output  1  image fully loaded (sticky).
- error  output  1  load aborted (sticky).

## Operation
- Image format: 2-byte word count N (low byte first), then N×4 data bytes.
- Data bytes of each word arrive LSB first: byte k fills bits [8k+7:8k].
- Receiver (uart_rx):
  - rx passes through a 2-flop synchronizer; both flops reset to 1.
  - A falling edge starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the event is a glitch and the receiver returns to idle with no output.
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT apart at mid-bit, then the stop bit.
  - Stop bit = 1 gives a one-cycle byte_valid with the byte; stop bit = 0 gives a one-cycle ferr pulse.
- Loader FSM states: LEN_LO, LEN_HI, DATA, DONE, ERR. Reset state is LEN_LO.
  - LEN_LO, on byte: latch count[7:0], go to LEN_HI.
  - LEN_HI, on byte: latch count[15:8]. Then:
    - count = 0 → DONE.
    - count > MAX_WORDS → ERR.
    - otherwise → DATA, with word index = 0 and byte index = 0.
  - DATA: each byte shifts into the word assembly register. On the 4th byte:
    - write the word to memory;
    - set byte index to 0 and increment the word index;
    - after the write for word N−1, go to DONE.
  - A ferr pulse in LEN_LO, LEN_HI or DATA → ERR.
  - DONE and ERR are terminal. They exit only by reset and ignore all further rx traffic.
- Outputs by state:
  - cpu_hold = 1 in every state except DONE.
  - done = 1 only in DONE.
  - error = 1 only in ERR.
- Width rules:
  - Word index is clog2(MAX_WORDS)+1 bits.
  - mem_addr = {zero-extend(word index), 2'b00}.
  - The count comparison is done at 16 bits.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wd 0, cpu_hold 1, done 0, error 0.
- byte_valid and ferr assert the cycle after the stop-bit mid-point sample.
- mem_we asserts exactly 1 cycle after byte_valid of a word's 4th byte, for exactly 1 cycle. mem_addr and mem_wd are valid in that same cycle and hold their values until the next write.
- State transitions (including to DONE or ERR) occur on the same edge that issues a write or consumes a length byte:
  - done rises in the mem_we cycle of the last word.
  - cpu_hold falls in the mem_we cycle of the last word.
- Reset asserted mid-frame or mid-image immediately returns everything to the reset values. A partially received word is discarded and the next byte after reset is treated as LEN_LO.
- Back-to-back frames (next start bit immediately after the stop bit) are accepted with no lost bytes.

## Structure
- Shared package (riscv_pkg): the loader state encoding and the length-field width constant (16).
- One sub-module, uart_rx: contains the synchronizer, bit timer, and the byte_valid/ferr outputs.
- instr_loader contains the FSM, the byte/word counters, and the assembly register.

## Test plan
All scenarios use CLKS_PER_BIT = 4, MAX_WORDS = 64.
- Load N=2, words 0x00500093 and 0x00A00113 → mem_we pulses twice at mem_addr 0x0 and 0x4 with those values; done=1, cpu_hold=0 in the second write cycle.
- Count bytes 0x00,0x00 → DONE with no mem_we; done=1, error=0.
- Count 65 (0x41,0x00) → error=1, cpu_hold=1, no writes; subsequent bytes produce no writes.
- Stop bit 0 on the 3rd data byte of word 0 → error=1, no mem_we, cpu_hold stays 1.
- 1-cycle low glitch on idle rx followed by a valid N=1 image of 0xDEADBEEF → exactly one write of 0xDEADBEEF at address 0, no spurious byte.
- Reset asserted mid-word 1 of an N=2 load, then a full N=1 image of 0x12345678 → a single write of 0x12345678 at address 0x0; done=1.
